multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer for the CPU bridge: NCH independent down-counters of width CW, each with its own preset, 8-bit prescaler, one-shot or auto-reload mode, and a sticky write-1-to-clear interrupt-pending bit. It sits on the same word-addressed peripheral bus as the single timer and supersedes it. It drives a combined IRQ to the CP0 interrupt input and a per-channel vector for debug.

## Interface
- NCH, 2, number of channels (1..8)
- CW, 32, counter/preset width (8..32); CHB = max(1, $clog2(NCH))
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all channels
- addr  in  CHB+2  word address [CHB+3:2]; low 2 bits = register, upper CHB bits = channel
- WE  in  1  write strobe, single cycle
- DATA_in  in  32  write data
- DATA_out  out  32  read data, combinational from addr
- IRQ  out  1  OR over channels of (pending & im)
- irq_vec  out  NCH  per-channel (pending & im)

## Operation
- Register map per channel: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 STATUS.
- CTRL: bit0 enable, bits2:1 mode (00 one-shot, 01 auto-reload, 1x reserved = one-shot), bit3 im, bits15:8 psc; other bits read 0.
- PRESET: DATA_in[CW-1:0] written; read zero-extended. COUNT read zero-extended; writes ignored.
- STATUS: bit0 pending; write with DATA_in[0]=1 clears it, 0 leaves it; other bits read 0.
- Channel index >= NCH: reads return 32'hbbbb_bbbb, writes ignored.
- Per-channel FSM, states IDLE, LOAD, CNTING:
  - Any CTRL write: latch CTRL fields, state <= LOAD, prescale counter <= 0. CTRL write takes precedence over counting that cycle.
  - LOAD: if enable, count <= preset, psc_cnt <= 0, -> CNTING; else stay.
  - CNTING, enable=1: tick when psc_cnt == psc (psc_cnt <= 0), else psc_cnt++. On tick: if count <= 1 expire, else count--.
  - Expire: pending <= 1. One-shot: count <= 0, enable <= 0, -> IDLE. Auto-reload: count <= preset, stay CNTING (no dead cycle).
  - CNTING, enable=0 cannot occur except via CTRL write (goes to LOAD).
  - IDLE: hold; leaves only on CTRL write.
- PRESET write while counting: affects next load/reload only.
- Pending set and W1C in the same cycle: set wins (pending stays 1).
- im=0 masks IRQ but pending still sets.

## Timing
- Reset values: ctrl=0, preset=0, count=0, psc_cnt=0, pending=0, state=LOAD; IRQ=0, irq_vec=0.
- With preset P>=1, psc S: CTRL write with enable at edge E -> count=P at E+1 -> pending=1 at edge E+1+P*(S+1).
- Auto-reload period exactly P*(S+1) cycles between pending-set edges.
- preset 0 behaves as preset 1.
- IRQ/irq_vec combinational from registered pending/im; no added latency.
- Reset mid-count: all channels return to reset values next edge, no IRQ.

## Structure
- Package timer_pkg: register offsets (REG_CTRL..REG_STATUS), mode encodings, CTRL bit positions, READ_DEFAULT 32'hbbbb_bbbb.
- Sub-module timer_channel (one instance per channel, parameter CW): FSM, prescaler, count, pending, register reads; top multi_timer does address decode, read mux, IRQ OR.

## Test plan
- Reset, read all registers of ch0/ch1 -> CTRL 0, PRESET 0, COUNT 0, STATUS 0, IRQ 0; read channel NCH -> 32'hbbbb_bbbb.
- ch0 preset 5, CTRL=0x9 (enable, one-shot, im) -> IRQ rises 6 edges after write, COUNT reads 0, CTRL bit0 reads 0; W1C STATUS -> IRQ drops next edge.
- ch1 preset 3, psc 2, CTRL=0x20B (auto-reload, im) -> pending sets every 9 cycles; clearing between expiries yields IRQ pulses 9 cycles apart.
- W1C on STATUS issued on the exact expiry edge -> pending remains 1.
- ch0 one-shot and ch1 auto-reload with im=0 on ch1 -> irq_vec = 2'b01 while both pending; IRQ follows ch0 only.
- Reset asserted mid-count with pending set -> next edge all state zero, IRQ 0, state LOAD with enable 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, mode
// encodings, CTRL field positions, the read value for unmapped channels and
// the per-channel FSM state type.
package timer_pkg;

   // Word offsets inside one channel's four-register window
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // CTRL.mode encodings; 1x is reserved and treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   // CTRL field positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_PSC_LSB  = 8;

   // Read value for channel indices that do not exist
   localparam logic [31:0] READ_DEFAULT = 32'hbbbb_bbbb;

   // Per-channel FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CNTING = 2'd2
   } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler,
// down-counter, sticky pending bit and the IDLE/LOAD/CNTING FSM.
// The bus handshake is a bare single-cycle write strobe: a write takes effect
// on the rising edge where we=1; reads are combinational from reg_sel with no
// ready/stall.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  reg_sel,
   input  logic        we,
   input  logic [31:0] data_in,
   output logic [31:0] rdata,
   output logic        irq,
   output state_t      state
);

   logic          enable, im;
   logic [1:0]    mode;
   logic [7:0]    psc;
   logic [CW-1:0] preset, count;
   logic [7:0]    psc_cnt;
   logic          pending;

   state_t        nxt_state;
   logic          nxt_enable, nxt_im, nxt_pending;
   logic [1:0]    nxt_mode;
   logic [7:0]    nxt_psc, nxt_psc_cnt;
   logic [CW-1:0] nxt_count;
   logic          expire;

   logic ctrl_wr, preset_wr, status_wr;
   assign ctrl_wr   = we && (reg_sel == REG_CTRL);
   assign preset_wr = we && (reg_sel == REG_PRESET);
   assign status_wr = we && (reg_sel == REG_STATUS);

   // Upper data bits and the gap in CTRL carry no register state
   logic unused_data;
   assign unused_data = ^{data_in[31:16], data_in[7:4]};

   // Register all channel state; reset leaves the FSM waiting in LOAD
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_LOAD;
         enable  <= 1'b0;
         mode    <= MODE_ONESHOT;
         im      <= 1'b0;
         psc     <= '0;
         preset  <= '0;
         count   <= '0;
         psc_cnt <= '0;
         pending <= 1'b0;
      end else begin
         state   <= nxt_state;
         enable  <= nxt_enable;
         mode    <= nxt_mode;
         im      <= nxt_im;
         psc     <= nxt_psc;
         count   <= nxt_count;
         psc_cnt <= nxt_psc_cnt;
         pending <= nxt_pending;
         if (preset_wr) preset <= data_in[CW-1:0];
      end
   end

   // Next-state logic: a CTRL write overrides whatever the FSM would do
   always_comb begin
      nxt_state   = state;
      nxt_enable  = enable;
      nxt_mode    = mode;
      nxt_im      = im;
      nxt_psc     = psc;
      nxt_count   = count;
      nxt_psc_cnt = psc_cnt;
      expire      = 1'b0;
      if (ctrl_wr) begin
         nxt_enable  = data_in[CTRL_EN_BIT];
         nxt_mode    = data_in[CTRL_MODE_LSB +: 2];
         nxt_im      = data_in[CTRL_IM_BIT];
         nxt_psc     = data_in[CTRL_PSC_LSB +: 8];
         nxt_psc_cnt = '0;
         nxt_state   = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (enable) begin
                  nxt_count   = preset;
                  nxt_psc_cnt = '0;
                  nxt_state   = ST_CNTING;
               end
            end
            ST_CNTING: begin
               if (enable) begin
                  if (psc_cnt == psc) begin
                     nxt_psc_cnt = '0;
                     // count <= 1 also covers preset 0, which then acts as 1
                     if (count <= CW'(1)) begin
                        expire = 1'b1;
                        if (mode == MODE_AUTO) begin
                           nxt_count = preset;
                        end else begin
                           nxt_count  = '0;
                           nxt_enable = 1'b0;
                           nxt_state  = ST_IDLE;
                        end
                     end else begin
                        nxt_count = count - CW'(1);
                     end
                  end else begin
                     nxt_psc_cnt = psc_cnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky pending: a new expiry beats a simultaneous write-1-to-clear
   always_comb begin
      nxt_pending = pending;
      if (expire)
         nxt_pending = 1'b1;
      else if (status_wr && data_in[0])
         nxt_pending = 1'b0;
   end

   // Register read mux for this channel
   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL: begin
            rdata[CTRL_EN_BIT]         = enable;
            rdata[CTRL_MODE_LSB +: 2]  = mode;
            rdata[CTRL_IM_BIT]         = im;
            rdata[CTRL_PSC_LSB +: 8]   = psc;
         end
         REG_PRESET: rdata = 32'(preset);
         REG_COUNT:  rdata = 32'(count);
         default:    rdata[0] = pending;
      endcase
   end

   assign irq = pending & im;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: splits the word address into channel and
// register, steers the write strobe, muxes read data and ORs the IRQs.
// ch_state exposes each channel's FSM state, two bits per channel.
module multi_timer
   import timer_pkg::*;
#(
   parameter int  NCH = 2,
   parameter int  CW  = 32,
   localparam int CHB = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CHB+1:0]   addr,
   input  logic             WE,
   input  logic [31:0]      DATA_in,
   output logic [31:0]      DATA_out,
   output logic             IRQ,
   output logic [NCH-1:0]   irq_vec,
   output logic [2*NCH-1:0] ch_state
);

   logic [31:0] ch_idx;
   logic [1:0]  reg_sel;
   logic [31:0] ch_rdata [NCH];
   state_t      ch_st    [NCH];

   assign ch_idx  = 32'(addr[CHB+1:2]);
   assign reg_sel = addr[1:0];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      timer_channel #(.CW(CW)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .reg_sel (reg_sel),
         .we      (WE && (ch_idx == 32'(g))),
         .data_in (DATA_in),
         .rdata   (ch_rdata[g]),
         .irq     (irq_vec[g]),
         .state   (ch_st[g])
      );
      assign ch_state[2*g +: 2] = ch_st[g];
   end

   // Read mux; indices with no channel behind them return READ_DEFAULT
   always_comb begin
      DATA_out = READ_DEFAULT;
      for (int i = 0; i < NCH; i++)
         if (ch_idx == 32'(i)) DATA_out = ch_rdata[i];
   end

   assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with three channels so that an unmapped
// channel index exists in the address space.
module tb_multi_timer;

   localparam int NCH = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  addr;
   logic        WE;
   logic [31:0] DATA_in;
   logic [31:0] DATA_out;
   logic        IRQ;
   logic [2:0]  irq_vec;
   logic [5:0]  ch_state;

   int total = 0;
   int bad   = 0;

   multi_timer #(.NCH(NCH), .CW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .WE       (WE),
      .DATA_in  (DATA_in),
      .DATA_out (DATA_out),
      .IRQ      (IRQ),
      .irq_vec  (irq_vec),
      .ch_state (ch_state)
   );

   // clock / reset
   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance n rising edges, stop 1 time unit after the last
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // register write landing on the next rising edge
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      addr    = a;
      DATA_in = d;
      WE      = 1'b1;
      @(posedge clk);
      #1;
      WE      = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, DATA_out, exp);
   endtask

   initial begin
      reset   = 1'b1;
      WE      = 1'b0;
      addr    = '0;
      DATA_in = '0;
      tick(2);
      reset = 1'b0;

      // reset values
      rd_chk("rst_ctrl0",   4'd0,  32'h0);
      rd_chk("rst_pre0",    4'd1,  32'h0);
      rd_chk("rst_cnt0",    4'd2,  32'h0);
      rd_chk("rst_stat0",   4'd3,  32'h0);
      rd_chk("rst_ctrl1",   4'd4,  32'h0);
      rd_chk("rst_pre1",    4'd5,  32'h0);
      rd_chk("rst_cnt1",    4'd6,  32'h0);
      rd_chk("rst_stat1",   4'd7,  32'h0);
      rd_chk("rst_badch",   4'd12, 32'hbbbb_bbbb);
      check("rst_irq",   32'(IRQ),      32'h0);
      check("rst_vec",   32'(irq_vec),  32'h0);
      check("rst_state", 32'(ch_state), 32'h15);

      // ch0 one-shot, preset 5, psc 0
      wr(4'd1, 32'd5);
      wr(4'd0, 32'h9);
      tick(1);
      rd_chk("os_load_cnt", 4'd2, 32'd5);
      check("os_cnting", 32'(ch_state[1:0]), 32'h2);
      tick(4);
      check("os_irq_early", 32'(IRQ), 32'h0);
      tick(1);
      check("os_irq_set", 32'(IRQ), 32'h1);
      check("os_vec", 32'(irq_vec), 32'h1);
      rd_chk("os_cnt_zero", 4'd2, 32'h0);
      rd_chk("os_ctrl_en0", 4'd0, 32'h8);
      rd_chk("os_status",   4'd3, 32'h1);
      check("os_idle", 32'(ch_state[1:0]), 32'h0);
      wr(4'd3, 32'h1);
      check("os_w1c_irq", 32'(IRQ), 32'h0);

      // ch1 auto-reload, preset 3, psc 2: period 9
      wr(4'd5, 32'd3);
      wr(4'd4, 32'h20B);          // edge E
      tick(9);                    // E+9
      check("ar_irq_early", 32'(IRQ), 32'h0);
      tick(1);                    // E+10
      check("ar_irq_1", 32'(IRQ), 32'h1);
      check("ar_vec_1", 32'(irq_vec), 32'h2);
      wr(4'd7, 32'h1);            // E+11
      check("ar_clr_1", 32'(IRQ), 32'h0);
      tick(7);                    // E+18
      check("ar_irq_gap", 32'(IRQ), 32'h0);
      tick(1);                    // E+19
      check("ar_irq_2", 32'(IRQ), 32'h1);
      tick(8);                    // E+27
      wr(4'd7, 32'h1);            // E+28, same edge as the expiry
      check("ar_w1c_race_irq", 32'(IRQ), 32'h1);
      rd_chk("ar_w1c_race_st", 4'd7, 32'h1);
      wr(4'd7, 32'h0);            // write 0 leaves pending alone
      rd_chk("ar_w0_keep", 4'd7, 32'h1);
      wr(4'd4, 32'h0);            // stop ch1
      wr(4'd7, 32'h1);
      check("ar_stop_irq", 32'(IRQ), 32'h0);
      check("ar_stop_state", 32'(ch_state[3:2]), 32'h1);

      // ch0 one-shot im=1 and ch1 auto-reload im=0
      wr(4'd1, 32'd2);
      wr(4'd0, 32'h9);            // edge A, ch0 pending at A+3
      wr(4'd5, 32'd2);
      wr(4'd4, 32'h3);            // edge A+2, ch1 pending at A+5
      tick(3);                    // A+5
      check("mask_vec", 32'(irq_vec), 32'h1);
      check("mask_irq", 32'(IRQ), 32'h1);
      rd_chk("mask_st0", 4'd3, 32'h1);
      rd_chk("mask_st1", 4'd7, 32'h1);
      wr(4'd3, 32'h1);
      check("mask_irq_clr", 32'(IRQ), 32'h0);
      check("mask_vec_clr", 32'(irq_vec), 32'h0);
      rd_chk("mask_st1_keep", 4'd7, 32'h1);

      // ch2 preset 0 acts as preset 1
      wr(4'd8, 32'h9);
      tick(1);
      check("p0_early", 32'(irq_vec), 32'h0);
      tick(1);
      check("p0_vec", 32'(irq_vec), 32'h4);
      wr(4'd11, 32'h1);
      check("p0_clr", 32'(IRQ), 32'h0);

      // writes to a nonexistent channel are dropped
      wr(4'd12, 32'h9);
      rd_chk("badch_wr", 4'd12, 32'hbbbb_bbbb);
      check("badch_irq", 32'(IRQ), 32'h0);

      // reset while counting with pending set
      wr(4'd1, 32'd50);
      wr(4'd0, 32'h9);
      tick(3);
      rd_chk("pre_rst_st1", 4'd7, 32'h1);
      check("pre_rst_cnting", 32'(ch_state[3:0]), 32'ha);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_irq",   32'(IRQ),      32'h0);
      check("mid_rst_vec",   32'(irq_vec),  32'h0);
      check("mid_rst_state", 32'(ch_state), 32'h15);
      rd_chk("mid_rst_ctrl0", 4'd0, 32'h0);
      rd_chk("mid_rst_cnt0",  4'd2, 32'h0);
      rd_chk("mid_rst_ctrl1", 4'd4, 32'h0);
      rd_chk("mid_rst_pre1",  4'd5, 32'h0);
      rd_chk("mid_rst_st1",   4'd7, 32'h0);
      reset = 1'b0;
      tick(2);
      check("post_rst_irq", 32'(IRQ), 32'h0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
